// File: rtl/wb_arbiter_pkg.sv
// ============================================================
// Package : wb_arbiter_pkg
// Shared writeback types, requester indices and index helpers.
// Rev     : 1.0
// ============================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int WB_ALU = 0;
    localparam int WB_MDU = 1;
    localparam int WB_LSU = 2;
    localparam int WB_REQ = 3;

    localparam int WB_DATA_W    = 32;
    localparam int WB_ROB_W     = 4;
    localparam int WB_RF_ADDR_W = 5;

    typedef struct packed {
        logic [WB_RF_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]    data;
        logic [WB_ROB_W-1:0]     rob_id;
        logic                    exp;
    } wb_req_t;

    // Increment an index modulo n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_rr.sv
// ============================================================
// Module : rr_arbiter
// Round-robin one-hot grant with a registered rotating pointer.
// Rev    : 1.0
// ============================================================
`default_nettype none

module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int REQ   = 3,
    localparam int IDX_W = $clog2(REQ)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [REQ-1:0]   req,
    input  logic             enable,
    output logic [REQ-1:0]   grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [REQ-1:0]   w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Scan from the pointer upward, wrapping, and take the first request.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < REQ; k++) begin
            logic [IDX_W:0] w_sum;
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(REQ);
            end
            if (!w_found && enable && req[w_sum[IDX_W-1:0]]) begin
                w_found                   = 1'b1;
                w_grant[w_sum[IDX_W-1:0]] = 1'b1;
                w_idx                     = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= IDX_W'(wrap_inc(int'(w_idx), REQ));
        end
    end

    assign grant     = w_grant;
    assign grant_idx = w_idx;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================
// Module : wb_arbiter
// Round-robin writeback arbiter with a one-entry output stage.
// Rev    : 1.0
// ============================================================
`default_nettype none

module wb_arbiter #(
    parameter  int DATA      = 32,
    parameter  int ROB_DEPTH = 16,
    parameter  int ROB       = $clog2(ROB_DEPTH),
    parameter  int REQ       = 3,
    parameter  int RF_ADDR   = 5,
    localparam int SRC_W     = $clog2(REQ)
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   flush,
    input  logic [REQ-1:0]         req_valid,
    output logic [REQ-1:0]         req_ready,
    input  logic [REQ*RF_ADDR-1:0] req_rd,
    input  logic [REQ*DATA-1:0]    req_data,
    input  logic [REQ*ROB-1:0]     req_rob_id,
    input  logic [REQ-1:0]         req_exp,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic                   wb_we,
    output logic [RF_ADDR-1:0]     wb_rd,
    output logic [DATA-1:0]        wb_data,
    output logic [ROB-1:0]         wb_rob_id,
    output logic                   wb_exp,
    output logic [SRC_W-1:0]       wb_src
);

    logic               r_valid;
    logic [RF_ADDR-1:0] r_rd;
    logic [DATA-1:0]    r_data;
    logic [ROB-1:0]     r_rob_id;
    logic               r_exp;
    logic [SRC_W-1:0]   r_src;

    logic               w_load;
    logic [REQ-1:0]     w_grant;
    logic [SRC_W-1:0]   w_idx;
    logic               w_any;

    // reset_ in the enable keeps every req_ready low while reset is held.
    assign w_load = reset_ && !flush && (!r_valid || wb_ready);
    assign w_any  = |w_grant;

    rr_arbiter #(
        .REQ       (REQ)
    ) u_rr (
        .clk       (clk),
        .reset_    (reset_),
        .req       (req_valid),
        .enable    (w_load),
        .grant     (w_grant),
        .grant_idx (w_idx)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_valid  <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
            r_rob_id <= '0;
            r_exp    <= 1'b0;
            r_src    <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_valid  <= w_any;
            if (w_any) begin
                r_rd     <= req_rd[w_idx*RF_ADDR +: RF_ADDR];
                r_data   <= req_data[w_idx*DATA +: DATA];
                r_rob_id <= req_rob_id[w_idx*ROB +: ROB];
                r_exp    <= req_exp[w_idx];
                r_src    <= w_idx;
            end
        end
    end

    assign req_ready = w_grant;
    assign wb_valid  = r_valid;
    assign wb_rd     = r_rd;
    assign wb_data   = r_data;
    assign wb_rob_id = r_rob_id;
    assign wb_exp    = r_exp;
    assign wb_src    = r_src;
    assign wb_we     = r_valid && (r_rd != '0) && !r_exp;

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port and the single ROB completion port among REQ execution-unit result producers (ALU, MUL/DIV, LSU).
- Sits between the execute units and cpu_regfiles / reorder_buffer inside the issue/writeback path.
- Arbitrates round-robin, registers the winner into a one-entry output stage and applies backpressure with valid/ready.
- Drops in-flight results on pipeline flush.

Parameters:
- DATA, `DataWidth` (32): result data width.
- ROB_DEPTH, `RobDepth` (16): reorder buffer entries.
- ROB, $clog2(ROB_DEPTH): ROB tag width.
- REQ, 3: number of requesters; must be ≥2.
- RF_ADDR, 5: architectural register index width.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; kill pending and registered results.
- req_valid  in  REQ  result valid per requester.
- req_ready  out  REQ  one-hot grant/accept per requester.
- req_rd  in  REQ*RF_ADDR  destination register; requester i occupies bits [i*RF_ADDR +: RF_ADDR].
- req_data  in  REQ*DATA  result data.
- req_rob_id  in  REQ*ROB  ROB tag.
- req_exp  in  REQ  exception flag.
- wb_valid  out  1  output stage holds a result.
- wb_ready  in  1  downstream (ROB completion) accepts.
- wb_we  out  1  regfile write enable; equals wb_valid && wb_rd!=0 && !wb_exp.
- wb_rd  out  RF_ADDR  destination register.
- wb_data  out  DATA  result data.
- wb_rob_id  out  ROB  ROB tag.
- wb_exp  out  1  exception flag.
- wb_src  out  $clog2(REQ)  index of the granted requester (debug/perf).

Behaviour:
- Reset (async, reset_=0): wb_valid=0, wb_rd=0, wb_data=0, wb_rob_id=0, wb_exp=0, wb_src=0, rr pointer=0. req_ready is 0 throughout reset.
- Stage-load condition: load = !flush && (!wb_valid || wb_ready).
- Grant:
  - When load, grant the first requester with req_valid set, searching from pointer ptr upward, mod REQ.
  - req_ready[i]=1 only for that requester; otherwise all zeros. req_ready is combinational from req_valid, ptr, wb_valid, wb_ready and flush.
  - A requester is accepted when req_valid[i] && req_ready[i] in the same cycle.
  - Requesters must hold valid and payload stable until accepted. The arbiter does not check this.
- Output stage:
  - On accept, the payload is registered, so outputs change on the next clock edge.
  - Latency is 1 cycle from accept to wb_valid.
  - If load is true and no request is present, wb_valid clears to 0.
  - If wb_valid && !wb_ready, the stage holds its contents and all req_ready are 0.
  - Back-to-back: when wb_ready=1, one result per cycle. Full throughput, no bubble.
- Pointer: after an accept from requester g, ptr <= (g+1) mod REQ. The wrap from REQ-1 goes to 0. Otherwise ptr holds. Any continuously asserting requester is served within REQ accepts.
- Flush:
  - flush=1 forces all req_ready=0 in that cycle.
  - wb_valid clears to 0 on the next edge, including when wb_ready=1 in the flush cycle. The registered result is discarded and not committed.
  - ptr is unchanged.
  - Payload registers may keep stale values; only wb_valid is authoritative.
- Simultaneous requests: exactly one grant per cycle; the others wait.
- wb_we is suppressed for rd=0 and for excepting results. ROB completion (wb_valid) is still raised for both.
- No assertion: rd/rob_id are not range-checked. Duplicate ROB tags are the producer's error.

Decomposition:
- Add to the shared CPU package/header:
  - wb_req_t packed struct {rd, data, rob_id, exp}.
  - REQ index constants WB_ALU=0, WB_MDU=1, WB_LSU=2.
- Sub-module rr_arbiter #(REQ):
  - Inputs: req vector, enable.
  - Outputs: one-hot grant, grant index.
  - Holds the pointer register and its clk/reset_.
  - Reusable elsewhere, e.g. for issue select.
- wb_arbiter instantiates rr_arbiter and owns the output register stage plus flush logic.

Test Plan:
- Reset mid-traffic: assert reset_=0 while wb_valid=1 -> wb_valid=0 and req_ready=0 immediately (async); after release, ptr=0 and the first grant goes to requester 0 if all are valid.
- All three valid continuously, wb_ready=1 -> grants in order 0,1,2,0,1,2; wb_src follows one cycle later; one result per cycle.
- Backpressure: requester 1 valid with rd=7, data=0xDEADBEEF, rob_id=5; wb_ready=0 for 3 cycles -> wb_valid stays 1 with unchanged payload and req_ready=000; on wb_ready=1 the next request is accepted in the same cycle.
- Zero/exception writes:
  - rd=0, data=0x1234 -> wb_valid=1, wb_we=0.
  - rd=3 with exp=1 -> wb_valid=1, wb_exp=1, wb_we=0.
- Flush: wb_valid=1 (rob_id=9) with flush=1 and wb_ready=1 -> next cycle wb_valid=0; req_ready=000 during the flush cycle; ptr unchanged.
- Wrap/fairness: ptr=2 with requesters 0 and 2 valid -> grant 2, then ptr=0 -> grant 0, then ptr=1 -> next grant 2.
